// File: rtl/ram_fifo_ctrl.sv
// Show-ahead FIFO controller wrapped around a simple dual-port RAM with a registered read address.
// It owns the pointers, occupancy counters, flags and the RAM write/read-address ports; q passes the RAM output through.
module ram_fifo_ctrl #(
    parameter int width   = 8,
    parameter int widthad = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               wrreq,
    input  logic [width-1:0]   data,
    output logic               full,
    input  logic               rdreq,
    output logic [width-1:0]   q,
    output logic               empty,
    output logic [widthad:0]   usedw,
    output logic               overflow,
    output logic               underflow,
    output logic [widthad-1:0] ram_wraddress,
    output logic               ram_wren,
    output logic [width-1:0]   ram_data,
    output logic [widthad-1:0] ram_rdaddress,
    input  logic [width-1:0]   ram_q
);

    localparam logic [widthad:0]   DEPTH_CNT = (widthad+1)'(1 << widthad);
    localparam logic [widthad:0]   CNT_ONE   = (widthad+1)'(1);
    localparam logic [widthad-1:0] PTR_ONE   = widthad'(1);

    logic [widthad-1:0] wr_ptr;
    logic [widthad-1:0] rd_ptr;
    logic [widthad:0]   avail;
    logic               wr_acc;
    logic               rd_acc;
    logic               wr_acc_p1;
    logic [widthad:0]   usedw_nxt;
    logic [widthad:0]   avail_nxt;

    assign full  = (usedw == DEPTH_CNT);
    assign empty = (avail == '0);

    // Requests arriving with rst or flush are dropped so nothing reaches the RAM.
    assign wr_acc = wrreq & ~full  & ~flush & ~rst;
    assign rd_acc = rdreq & ~empty & ~flush & ~rst;

    assign ram_wren      = wr_acc;
    assign ram_data      = data;
    assign ram_wraddress = wr_ptr;
    assign ram_rdaddress = rd_acc ? rd_ptr + PTR_ONE : rd_ptr;
    assign q             = ram_q;

    always_comb begin
        usedw_nxt = usedw;
        case ({wr_acc, rd_acc})
            2'b10:   usedw_nxt = usedw + CNT_ONE;
            2'b01:   usedw_nxt = usedw - CNT_ONE;
            default: usedw_nxt = usedw;
        endcase
    end

    // A write is only readable once the registered copy of its accept has landed.
    always_comb begin
        avail_nxt = avail;
        case ({wr_acc_p1, rd_acc})
            2'b10:   avail_nxt = avail + CNT_ONE;
            2'b01:   avail_nxt = avail - CNT_ONE;
            default: avail_nxt = avail;
        endcase
    end

    // Stage p1: pointers, counters, delayed write accept and sticky flags.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            usedw     <= '0;
            avail     <= '0;
            wr_acc_p1 <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + PTR_ONE;
            if (rd_acc) rd_ptr <= rd_ptr + PTR_ONE;
            usedw     <= usedw_nxt;
            avail     <= avail_nxt;
            wr_acc_p1 <= wr_acc;
            if (wrreq && full)  overflow  <= 1'b1;
            if (rdreq && empty) underflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Directed bench for ram_fifo_ctrl with a small registered-read-address RAM model attached.
module tb_ram_fifo_ctrl;

    logic       clk = 1'b0;
    logic       rst, flush, wrreq, rdreq;
    logic [7:0] data;
    logic       full, empty, overflow, underflow;
    logic [7:0] q;
    logic [4:0] usedw;
    logic [3:0] ram_wraddress, ram_rdaddress;
    logic       ram_wren;
    logic [7:0] ram_data, ram_q;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ram_fifo_ctrl #(.width(8), .widthad(4)) dut (
        .clk(clk), .rst(rst), .flush(flush), .wrreq(wrreq), .data(data), .full(full),
        .rdreq(rdreq), .q(q), .empty(empty), .usedw(usedw), .overflow(overflow),
        .underflow(underflow), .ram_wraddress(ram_wraddress), .ram_wren(ram_wren),
        .ram_data(ram_data), .ram_rdaddress(ram_rdaddress), .ram_q(ram_q)
    );

    logic [7:0] mem [16];
    logic [3:0] rdaddr_r;
    always @(posedge clk) begin
        if (ram_wren) mem[ram_wraddress] <= ram_data;
        rdaddr_r <= ram_rdaddress;
    end
    assign ram_q = mem[rdaddr_r];

    task tick;
        @(posedge clk);
        #1;
    endtask

    task do_flush;
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task test_reset;
        rst = 1'b1; flush = 1'b0; wrreq = 1'b0; rdreq = 1'b0; data = 8'h00;
        tick(); tick();
        rst = 1'b0;
        tick();
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b expected 1", empty); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b expected 0", full); end
        checks++; if (usedw !== 5'd0) begin errors++; $display("FAIL reset_usedw: got %0d expected 0", usedw); end
        checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin errors++; $display("FAIL reset_flags: got %b%b expected 00", overflow, underflow); end
        checks++; if (ram_wren !== 1'b0) begin errors++; $display("FAIL reset_wren: got %b expected 0", ram_wren); end
        rdreq = 1'b1;
        tick();
        rdreq = 1'b0;
        checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL underflow_set: got %b expected 1", underflow); end
        checks++; if (usedw !== 5'd0) begin errors++; $display("FAIL underflow_usedw: got %0d expected 0", usedw); end
    endtask

    task test_single;
        do_flush();
        checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL flush_underflow: got %b expected 0", underflow); end
        wrreq = 1'b1; data = 8'h11;
        #1;
        checks++; if (ram_wren !== 1'b1 || ram_wraddress !== 4'd0 || ram_data !== 8'h11) begin
            errors++; $display("FAIL single_wrport: got wren=%b addr=%0d data=%h expected 1 0 11", ram_wren, ram_wraddress, ram_data); end
        tick();
        wrreq = 1'b0;
        checks++; if (usedw !== 5'd1) begin errors++; $display("FAIL single_usedw: got %0d expected 1", usedw); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL single_empty_E: got %b expected 1", empty); end
        tick();
        checks++; if (empty !== 1'b0) begin errors++; $display("FAIL single_empty_E1: got %b expected 0", empty); end
        checks++; if (q !== 8'h11) begin errors++; $display("FAIL single_q: got %h expected 11", q); end
        rdreq = 1'b1;
        #1;
        checks++; if (ram_rdaddress !== 4'd1) begin errors++; $display("FAIL single_rdaddr: got %0d expected 1", ram_rdaddress); end
        tick();
        rdreq = 1'b0;
        checks++; if (empty !== 1'b1 || usedw !== 5'd0) begin errors++; $display("FAIL single_after_read: got empty=%b usedw=%0d expected 1 0", empty, usedw); end
    endtask

    task test_fill;
        do_flush();
        for (int i = 0; i < 16; i++) begin
            wrreq = 1'b1; data = 8'(i);
            tick();
        end
        checks++; if (full !== 1'b1 || usedw !== 5'd16) begin errors++; $display("FAIL fill_full: got full=%b usedw=%0d expected 1 16", full, usedw); end
        data = 8'hEE;
        #1;
        checks++; if (ram_wren !== 1'b0) begin errors++; $display("FAIL fill_wren_when_full: got %b expected 0", ram_wren); end
        tick();
        wrreq = 1'b0;
        checks++; if (overflow !== 1'b1 || usedw !== 5'd16) begin errors++; $display("FAIL fill_overflow: got ovf=%b usedw=%0d expected 1 16", overflow, usedw); end
        tick();
        for (int i = 0; i < 16; i++) begin
            checks++; if (empty !== 1'b0 || q !== 8'(i)) begin errors++; $display("FAIL fill_read%0d: got empty=%b q=%h expected 0 %h", i, empty, q, 8'(i)); end
            rdreq = 1'b1;
            tick();
        end
        rdreq = 1'b0;
        checks++; if (empty !== 1'b1 || usedw !== 5'd0) begin errors++; $display("FAIL fill_drained: got empty=%b usedw=%0d expected 1 0", empty, usedw); end
    endtask

    task test_wrap;
        int wcnt, rcnt, maxu;
        do_flush();
        for (int i = 0; i < 10; i++) begin
            wrreq = 1'b1; data = 8'(i);
            tick();
        end
        wrreq = 1'b0;
        tick();
        rdreq = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        rdreq = 1'b0;
        checks++; if (usedw !== 5'd0 || ram_wraddress !== 4'd10) begin errors++; $display("FAIL wrap_prime: got usedw=%0d wraddr=%0d expected 0 10", usedw, ram_wraddress); end
        wcnt = 0; rcnt = 0; maxu = 0;
        for (int cyc = 0; cyc < 100 && rcnt < 20; cyc++) begin
            wrreq = (wcnt < 20); data = 8'(160 + wcnt); rdreq = 1'b1;
            #1;
            if (!empty) begin
                checks++;
                if (q !== 8'(160 + rcnt)) begin errors++; $display("FAIL wrap_order%0d: got %h expected %h", rcnt, q, 8'(160 + rcnt)); end
                rcnt++;
            end
            if (wrreq && !full) wcnt++;
            tick();
            if (int'(usedw) > maxu) maxu = int'(usedw);
        end
        wrreq = 1'b0; rdreq = 1'b0;
        checks++; if (rcnt != 20) begin errors++; $display("FAIL wrap_count: got %0d reads expected 20", rcnt); end
        checks++; if (maxu > 2) begin errors++; $display("FAIL wrap_maxusedw: got %0d expected <=2", maxu); end
        checks++; if (empty !== 1'b1 || usedw !== 5'd0) begin errors++; $display("FAIL wrap_end: got empty=%b usedw=%0d expected 1 0", empty, usedw); end
    endtask

    task test_back_to_back;
        do_flush();
        for (int i = 0; i < 5; i++) begin
            wrreq = 1'b1; data = 8'(8'h50 + i);
            tick();
        end
        wrreq = 1'b0;
        tick();
        wrreq = 1'b1; data = 8'h55; rdreq = 1'b1;
        #1;
        checks++; if (ram_wraddress !== 4'd5 || ram_rdaddress !== 4'd1 || q !== 8'h50) begin
            errors++; $display("FAIL b2b_pre: got wa=%0d ra=%0d q=%h expected 5 1 50", ram_wraddress, ram_rdaddress, q); end
        tick();
        wrreq = 1'b0; rdreq = 1'b0;
        #1;
        checks++; if (usedw !== 5'd5) begin errors++; $display("FAIL b2b_usedw: got %0d expected 5", usedw); end
        checks++; if (ram_wraddress !== 4'd6 || ram_rdaddress !== 4'd1 || q !== 8'h51) begin
            errors++; $display("FAIL b2b_ptrs: got wa=%0d ra=%0d q=%h expected 6 1 51", ram_wraddress, ram_rdaddress, q); end
        for (int i = 0; i < 11; i++) begin
            wrreq = 1'b1; data = 8'(8'h56 + i);
            tick();
        end
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL b2b_full: got %b expected 1", full); end
        rdreq = 1'b1; data = 8'hEE;
        tick();
        wrreq = 1'b0; rdreq = 1'b0;
        checks++; if (overflow !== 1'b1 || usedw !== 5'd15 || full !== 1'b0) begin
            errors++; $display("FAIL b2b_fullrw: got ovf=%b usedw=%0d full=%b expected 1 15 0", overflow, usedw, full); end
        checks++; if (q !== 8'h52) begin errors++; $display("FAIL b2b_head: got %h expected 52", q); end
        rdreq = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        rdreq = 1'b0;
        checks++; if (usedw !== 5'd7 || q !== 8'h5A) begin errors++; $display("FAIL b2b_drain: got usedw=%0d q=%h expected 7 5a", usedw, q); end
    endtask

    task test_flush;
        flush = 1'b1; wrreq = 1'b1; rdreq = 1'b1; data = 8'hEE;
        #1;
        checks++; if (ram_wren !== 1'b0) begin errors++; $display("FAIL flush_wren: got %b expected 0", ram_wren); end
        tick();
        flush = 1'b0; wrreq = 1'b0; rdreq = 1'b0;
        checks++; if (usedw !== 5'd0 || empty !== 1'b1 || full !== 1'b0) begin
            errors++; $display("FAIL flush_state: got usedw=%0d empty=%b full=%b expected 0 1 0", usedw, empty, full); end
        checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin errors++; $display("FAIL flush_flags: got %b%b expected 00", overflow, underflow); end
        tick();
        checks++; if (empty !== 1'b1 || ram_wraddress !== 4'd0) begin errors++; $display("FAIL flush_idle: got empty=%b wa=%0d expected 1 0", empty, ram_wraddress); end
        wrreq = 1'b1; data = 8'h77;
        tick();
        wrreq = 1'b0;
        tick();
        checks++; if (empty !== 1'b0 || q !== 8'h77) begin errors++; $display("FAIL flush_newdata: got empty=%b q=%h expected 0 77", empty, q); end
        rdreq = 1'b1;
        tick();
        rdreq = 1'b0;
        checks++; if (empty !== 1'b1 || usedw !== 5'd0) begin errors++; $display("FAIL flush_nostale: got empty=%b usedw=%0d expected 1 0", empty, usedw); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_wrap();
        test_back_to_back();
        test_flush();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
